pc_fetch_unit: RTL and testbench

Owns the architectural program counter and fetches one 32-bit instruction per executed instruction. Holds `CurrentPC`, issues a request/grant read to instruction memory, presents the returned word to decode, and waits for the next-PC logic to return a resolved `NextPC`. It closes the loop opened by the next-PC computation: that logic consumes `CurrentPC` and produces `NextPC`; this block consumes `NextPC` and produces `CurrentPC`.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/pc_fetch_unit.sv | 132 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-counter fetch unit.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 64;

    // Low PC bits that must be zero for a 4-byte aligned instruction address.
    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

    // Fetch sequencing: request, wait for data, execute, or stuck on a fault.
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        WAIT  = 2'b01,
        EXEC  = 2'b10,
        FAULT = 2'b11
    } fetch_state_e;

    // True when a PC can legally be fetched.
    function automatic logic pc_is_aligned(input logic [PC_W-1:0] pc);
        return (pc[1:0] & PC_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// Program-counter owner and instruction fetcher: one request/grant read per
// executed instruction, then waits for the resolved next PC.
// Optional feature: define FETCH_RETIRE_COUNT_EN to add the RetiredCount port.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    // Must be 4-byte aligned.
    parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [PC_W-1:0]    NextPC,
    input  logic               NextPCValid,
    output logic               IMemReq,
    output logic [PC_W-1:0]    IMemAddr,
    input  logic               IMemGnt,
    input  logic               IMemRvalid,
    input  logic [INSTR_W-1:0] IMemRdata,
    output logic [PC_W-1:0]    CurrentPC,
    output logic [INSTR_W-1:0] Instruction,
    output logic               InstrValid,
    output logic               Misaligned
`ifdef FETCH_RETIRE_COUNT_EN
    ,
    output logic [PC_W-1:0]    RetiredCount
`endif
);

    fetch_state_e        state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                misaligned_q, misaligned_d;

    // Next-state: FSM sequencing, PC update and instruction capture.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        misaligned_d = misaligned_q;
        case (state_q)
            FETCH: begin
                if (IMemGnt) begin
                    if (IMemRvalid) begin
                        // Zero-wait memory: data arrives with the grant.
                        instr_d = IMemRdata;
                        state_d = EXEC;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (IMemRvalid) begin
                    instr_d = IMemRdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (NextPCValid) begin
                    if (pc_is_aligned(NextPC)) begin
                        pc_d    = NextPC;
                        state_d = FETCH;
                    end else begin
                        // PC stays on the faulting instruction for inspection.
                        misaligned_d = 1'b1;
                        state_d      = FAULT;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Outputs: request and valid are masked by Reset so nothing leaks while
    // reset is held, regardless of the state the register still shows.
    always_comb begin
        IMemReq     = (state_q == FETCH) && !Reset;
        InstrValid  = (state_q == EXEC) && !Reset;
        IMemAddr    = pc_q;
        CurrentPC   = pc_q;
        Instruction = instr_q;
        Misaligned  = misaligned_q;
    end

`ifdef FETCH_RETIRE_COUNT_EN
    logic [PC_W-1:0] retired_q, retired_d;
    logic            retire;

    // An instruction retires when its successor PC is accepted and aligned.
    assign retire = (state_q == EXEC) && NextPCValid && pc_is_aligned(NextPC);

    // Retire counter next-state; wraps naturally at 2^64.
    always_comb begin
        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + 64'd1;
        end
    end

    // Retire counter register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign RetiredCount = retired_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit with randomized memory latency,
// instruction data and next-PC values against a transaction-level model.
module tb_pc_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        CLK;
    logic        Reset;
    logic [63:0] NextPC;
    logic        NextPCValid;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRvalid;
    logic [31:0] IMemRdata;
    logic [63:0] CurrentPC;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        Misaligned;
    logic [63:0] RetiredCount;

    int errors = 0;
    int checks = 0;

    // Model of architectural state.
    logic [63:0] exp_pc;
    logic [63:0] exp_ret;
    logic [31:0] exp_instr;

    pc_fetch_unit #(
        .RESET_PC(RST_PC)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .NextPC      (NextPC),
        .NextPCValid (NextPCValid),
        .IMemReq     (IMemReq),
        .IMemAddr    (IMemAddr),
        .IMemGnt     (IMemGnt),
        .IMemRvalid  (IMemRvalid),
        .IMemRdata   (IMemRdata),
        .CurrentPC   (CurrentPC),
        .Instruction (Instruction),
        .InstrValid  (InstrValid),
        .Misaligned  (Misaligned)
`ifdef FETCH_RETIRE_COUNT_EN
        ,
        .RetiredCount(RetiredCount)
`endif
    );

`ifndef FETCH_RETIRE_COUNT_EN
    assign RetiredCount = '0;
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_retired(input string name);
`ifdef FETCH_RETIRE_COUNT_EN
        checks++;
        if (RetiredCount !== exp_ret) begin
            errors++;
            $display("FAIL %s: RetiredCount got %h want %h", name, RetiredCount, exp_ret);
        end
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    // Apply reset for two cycles, then release and check the first request.
    task automatic test_reset();
        Reset = 1'b1;
        IMemGnt = 1'b0;
        IMemRvalid = 1'b0;
        NextPCValid = 1'b0;
        step();
        step();
        exp_pc = RST_PC;
        exp_ret = '0;
        exp_instr = '0;
        checks++;
        if (IMemReq !== 1'b0) begin
            errors++; $display("FAIL rst_req: got %b want 0", IMemReq);
        end
        checks++;
        if (InstrValid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: got %b want 0", InstrValid);
        end
        checks++;
        if (CurrentPC !== RST_PC || IMemAddr !== RST_PC) begin
            errors++;
            $display("FAIL rst_pc: got %h/%h want %h", CurrentPC, IMemAddr, RST_PC);
        end
        checks++;
        if (Instruction !== 32'h0 || Misaligned !== 1'b0) begin
            errors++;
            $display("FAIL rst_regs: instr %h mis %b want 0/0", Instruction, Misaligned);
        end
        check_retired("rst_retired");
        Reset = 1'b0;
        step();
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== RST_PC) begin
            errors++;
            $display("FAIL rst_release: req %b addr %h want 1 %h", IMemReq, IMemAddr, RST_PC);
        end
    endtask

    // One full instruction: gd stall cycles before grant, data rd cycles
    // after grant (0 = same cycle), hold extra EXEC cycles with stray rvalid.
    task automatic fetch_one(input int gd, input int rd, input int hold,
                             input logic [31:0] data, input logic [63:0] np);
        for (int i = 0; i < gd; i++) begin
            IMemGnt = 1'b0;
            IMemRvalid = 1'b0;
            checks++;
            if (IMemReq !== 1'b1 || IMemAddr !== exp_pc || InstrValid !== 1'b0) begin
                errors++;
                $display("FAIL stall: req %b addr %h vld %b want 1 %h 0",
                         IMemReq, IMemAddr, InstrValid, exp_pc);
            end
            step();
        end
        IMemGnt = 1'b1;
        IMemRvalid = (rd == 0);
        IMemRdata = (rd == 0) ? data : $urandom;
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== exp_pc) begin
            errors++;
            $display("FAIL grant: req %b addr %h want 1 %h", IMemReq, IMemAddr, exp_pc);
        end
        step();
        IMemGnt = 1'b0;
        IMemRvalid = 1'b0;
        if (rd > 0) begin
            for (int i = 0; i < rd - 1; i++) begin
                IMemRdata = $urandom;
                checks++;
                if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin
                    errors++;
                    $display("FAIL wait: req %b vld %b want 0 0", IMemReq, InstrValid);
                end
                step();
            end
            IMemRvalid = 1'b1;
            IMemRdata = data;
            step();
            IMemRvalid = 1'b0;
        end
        exp_instr = data;
        for (int h = 0; h < hold; h++) begin
            checks++;
            if (InstrValid !== 1'b1 || Instruction !== exp_instr) begin
                errors++;
                $display("FAIL exec_hold: vld %b instr %h want 1 %h",
                         InstrValid, Instruction, exp_instr);
            end
            IMemRvalid = 1'b1;
            IMemRdata = ~data;
            NextPCValid = 1'b0;
            step();
            IMemRvalid = 1'b0;
        end
        checks++;
        if (InstrValid !== 1'b1 || Instruction !== exp_instr || CurrentPC !== exp_pc
            || IMemReq !== 1'b0) begin
            errors++;
            $display("FAIL exec: vld %b instr %h pc %h req %b want 1 %h %h 0",
                     InstrValid, Instruction, CurrentPC, IMemReq, exp_instr, exp_pc);
        end
        NextPC = np;
        NextPCValid = 1'b1;
        step();
        NextPCValid = 1'b0;
        NextPC = {$urandom, $urandom};
        if (np[1:0] == 2'b00) begin
            exp_pc = np;
            exp_ret = exp_ret + 64'd1;
            checks++;
            if (IMemReq !== 1'b1 || IMemAddr !== exp_pc || InstrValid !== 1'b0
                || Misaligned !== 1'b0) begin
                errors++;
                $display("FAIL next_pc: req %b addr %h vld %b mis %b want 1 %h 0 0",
                         IMemReq, IMemAddr, InstrValid, Misaligned, exp_pc);
            end
        end else begin
            checks++;
            if (Misaligned !== 1'b1 || IMemReq !== 1'b0 || CurrentPC !== exp_pc) begin
                errors++;
                $display("FAIL misalign: mis %b req %b pc %h want 1 0 %h",
                         Misaligned, IMemReq, CurrentPC, exp_pc);
            end
        end
        checks++;
        if (Instruction !== exp_instr) begin
            errors++;
            $display("FAIL instr_hold: got %h want %h", Instruction, exp_instr);
        end
        check_retired("retired");
    endtask

    task automatic test_zero_wait();
        fetch_one(0, 0, 0, 32'h8B020020, 64'h1004);
        fetch_one(0, 0, 0, $urandom, 64'h1008);
    endtask

    task automatic test_stall();
        fetch_one(3, 2, 2, $urandom, 64'h100C);
    endtask

    task automatic test_branch();
        fetch_one(1, 1, 0, $urandom, 64'h0FF0);
        checks++;
        if (CurrentPC !== 64'h0FF0) begin
            errors++; $display("FAIL branch: pc %h want 0ff0", CurrentPC);
        end
        fetch_one(0, 0, 1, $urandom, 64'hFFFF_FFFF_FFFF_FFFC);
        fetch_one(0, 3, 0, $urandom, 64'h0);
    endtask

    task automatic test_random();
        logic [63:0] np;
        for (int n = 0; n < 25; n++) begin
            np = {$urandom, $urandom} & ~64'h3;
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2)), $urandom, np);
        end
    endtask

    task automatic test_misaligned();
        test_reset();
        fetch_one(0, 1, 0, 32'hDEAD_BEEF, 64'h1004);
        fetch_one(0, 0, 0, $urandom, 64'h1006);
        for (int i = 0; i < 6; i++) begin
            IMemGnt = 1'($urandom);
            IMemRvalid = 1'($urandom);
            IMemRdata = $urandom;
            NextPCValid = 1'($urandom);
            NextPC = {$urandom, $urandom} & ~64'h3;
            step();
            checks++;
            if (Misaligned !== 1'b1 || IMemReq !== 1'b0 || CurrentPC !== exp_pc
                || Instruction !== exp_instr) begin
                errors++;
                $display("FAIL fault_hold: mis %b req %b pc %h instr %h want 1 0 %h %h",
                         Misaligned, IMemReq, CurrentPC, Instruction, exp_pc, exp_instr);
            end
            check_retired("fault_retired");
        end
        IMemGnt = 1'b0;
        IMemRvalid = 1'b0;
        NextPCValid = 1'b0;
        test_reset();
    endtask

    task automatic test_reset_in_wait();
        fetch_one(0, 0, 0, $urandom, 64'h2000);
        IMemGnt = 1'b1;
        IMemRvalid = 1'b0;
        step();
        IMemGnt = 1'b0;
        Reset = 1'b1;
        step();
        IMemRvalid = 1'b1;
        IMemRdata = 32'h1234_5678;
        checks++;
        if (IMemReq !== 1'b0 || InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL wait_rst: req %b vld %b want 0 0", IMemReq, InstrValid);
        end
        step();
        IMemRvalid = 1'b0;
        Reset = 1'b0;
        exp_pc = RST_PC;
        exp_ret = '0;
        exp_instr = '0;
        step();
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== RST_PC || InstrValid !== 1'b0
            || Instruction !== 32'h0) begin
            errors++;
            $display("FAIL wait_rst_release: req %b addr %h vld %b instr %h want 1 %h 0 0",
                     IMemReq, IMemAddr, InstrValid, Instruction, RST_PC);
        end
        check_retired("wait_rst_retired");
        step();
        checks++;
        if (InstrValid !== 1'b0 || IMemReq !== 1'b1) begin
            errors++;
            $display("FAIL wait_rst_idle: vld %b req %b want 0 1", InstrValid, IMemReq);
        end
        fetch_one(0, 0, 0, $urandom, 64'h1004);
    endtask

    initial begin
        Reset = 1'b1;
        NextPC = '0;
        NextPCValid = 1'b0;
        IMemGnt = 1'b0;
        IMemRvalid = 1'b0;
        IMemRdata = '0;
        exp_pc = RST_PC;
        exp_ret = '0;
        exp_instr = '0;
        #1;
        test_reset();
        test_zero_wait();
        test_stall();
        test_branch();
        test_random();
        test_misaligned();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
